// File: rtl/bp_me_nonsynth_lce_trace_scheduler.sv
// LCE trace scheduler: captures fired events on four LCE-CCE channels into small
// per-channel FIFOs, timestamps them, and serializes them round-robin to one port.
module bp_me_nonsynth_lce_trace_scheduler #(
  parameter int unsigned msg_width_p   = 8,
  parameter int unsigned fifo_els_p    = 2,
  parameter int unsigned stamp_width_p = 32,
  parameter int unsigned drop_width_p  = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        en_i,
  input  logic [3:0]                  ev_v_i,
  input  logic [4*msg_width_p-1:0]    ev_msg_i,
  output logic                        ev_v_o,
  output logic [1:0]                  ev_chan_o,
  output logic [stamp_width_p-1:0]    ev_stamp_o,
  output logic [msg_width_p-1:0]      ev_msg_o,
  input  logic                        ev_yumi_i,
  output logic [4*drop_width_p-1:0]   drop_cnt_o,
  output logic                        overflow_o
);

  localparam int unsigned num_chan_lp    = 4;
  localparam int unsigned ptr_width_lp   = $clog2(fifo_els_p);
  localparam int unsigned cnt_width_lp   = $clog2(fifo_els_p + 1);
  localparam int unsigned entry_width_lp = stamp_width_p + msg_width_p;

  typedef enum logic {e_unlocked, e_locked} arb_state_e;

  logic [entry_width_lp-1:0] mem_r    [num_chan_lp][fifo_els_p];
  logic [ptr_width_lp-1:0]   rd_ptr_r [num_chan_lp];
  logic [ptr_width_lp-1:0]   wr_ptr_r [num_chan_lp];
  logic [cnt_width_lp-1:0]   count_r  [num_chan_lp];
  logic [drop_width_p-1:0]   drop_r   [num_chan_lp];
  logic [stamp_width_p-1:0]  stamp_r;

  arb_state_e state_r, state_n;
  logic [1:0] last_r, last_n;
  logic [1:0] lock_chan_r, lock_chan_n;

  logic [3:0] full, empty, push, drop, pop;
  logic [1:0] scan_grant, scan_idx, grant;
  logic       scan_found, yumi_fire;
  logic [entry_width_lp-1:0] head;

  // Per-channel FIFO status and push/drop decisions (full is pre-pop)
  always_comb begin
    full  = '0;
    empty = '0;
    push  = '0;
    drop  = '0;
    for (int c = 0; c < num_chan_lp; c++) begin
      full[c]  = (count_r[c] == cnt_width_lp'(fifo_els_p));
      empty[c] = (count_r[c] == '0);
      push[c]  = ev_v_i[c] & en_i & ~full[c];
      drop[c]  = ev_v_i[c] & en_i &  full[c];
    end
  end

  // Arbiter next-state and output port
  always_comb begin
    state_n     = state_r;
    last_n      = last_r;
    lock_chan_n = lock_chan_r;
    scan_grant  = '0;
    scan_idx    = '0;
    scan_found  = 1'b0;
    grant       = '0;
    ev_v_o      = 1'b0;
    yumi_fire   = 1'b0;
    pop         = '0;

    for (int i = 1; i <= num_chan_lp; i++) begin
      scan_idx = last_r + 2'(i);
      if (!scan_found && !empty[scan_idx]) begin
        scan_found = 1'b1;
        scan_grant = scan_idx;
      end
    end

    if (state_r == e_locked) begin
      grant  = lock_chan_r;
      ev_v_o = 1'b1;
    end else begin
      grant  = scan_grant;
      ev_v_o = scan_found;
    end

    yumi_fire   = ev_yumi_i & ev_v_o;
    pop[grant]  = yumi_fire;

    if (yumi_fire) begin
      state_n = e_unlocked;
      last_n  = grant;
    end else if (ev_v_o) begin
      state_n     = e_locked;
      lock_chan_n = grant;
    end
  end

  assign head       = mem_r[grant][rd_ptr_r[grant]];
  assign ev_chan_o  = grant;
  assign ev_stamp_o = head[entry_width_lp-1 -: stamp_width_p];
  assign ev_msg_o   = head[msg_width_p-1:0];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= e_unlocked;
      last_r      <= 2'd3;
      lock_chan_r <= 2'd0;
    end else begin
      state_r     <= state_n;
      last_r      <= last_n;
      lock_chan_r <= lock_chan_n;
    end
  end

  // Stamp counter, FIFO pointers/counts and drop accounting
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stamp_r    <= '0;
      overflow_o <= 1'b0;
      for (int c = 0; c < num_chan_lp; c++) begin
        rd_ptr_r[c] <= '0;
        wr_ptr_r[c] <= '0;
        count_r[c]  <= '0;
        drop_r[c]   <= '0;
      end
    end else begin
      stamp_r <= stamp_r + stamp_width_p'(1);
      if (|drop) overflow_o <= 1'b1;
      for (int c = 0; c < num_chan_lp; c++) begin
        if (push[c]) wr_ptr_r[c] <= wr_ptr_r[c] + ptr_width_lp'(1);
        if (pop[c])  rd_ptr_r[c] <= rd_ptr_r[c] + ptr_width_lp'(1);
        case ({push[c], pop[c]})
          2'b10:   count_r[c] <= count_r[c] + cnt_width_lp'(1);
          2'b01:   count_r[c] <= count_r[c] - cnt_width_lp'(1);
          default: count_r[c] <= count_r[c];
        endcase
        if (drop[c] && (drop_r[c] != '1)) drop_r[c] <= drop_r[c] + drop_width_p'(1);
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_r
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < num_chan_lp; c++) begin
      if (push[c]) mem_r[c][wr_ptr_r[c]] <= {stamp_r, ev_msg_i[c*msg_width_p +: msg_width_p]};
    end
  end

  always_comb begin
    drop_cnt_o = '0;
    for (int c = 0; c < num_chan_lp; c++) begin
      drop_cnt_o[c*drop_width_p +: drop_width_p] = drop_r[c];
    end
  end

  yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i) ev_yumi_i |-> ev_v_o);

endmodule

// File: tb/tb_bp_me_nonsynth_lce_trace_scheduler.sv
// Bench for the LCE trace scheduler: directed scenarios plus random traffic,
// checked against a queue-based reference model of the scheduling rules.
module tb_bp_me_nonsynth_lce_trace_scheduler;

  localparam int unsigned msg_w   = 8;
  localparam int unsigned els     = 2;
  localparam int unsigned stamp_w = 32;
  localparam int unsigned drop_w  = 8;

  logic                    clk_i = 1'b0;
  logic                    reset_i = 1'b1;
  logic                    en_i = 1'b0;
  logic [3:0]              ev_v_i = '0;
  logic [4*msg_w-1:0]      ev_msg_i = '0;
  logic                    ev_v_o;
  logic [1:0]              ev_chan_o;
  logic [stamp_w-1:0]      ev_stamp_o;
  logic [msg_w-1:0]        ev_msg_o;
  logic                    ev_yumi_i = 1'b0;
  logic [4*drop_w-1:0]     drop_cnt_o;
  logic                    overflow_o;

  bp_me_nonsynth_lce_trace_scheduler #(
    .msg_width_p(msg_w), .fifo_els_p(els), .stamp_width_p(stamp_w), .drop_width_p(drop_w)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .ev_v_i(ev_v_i), .ev_msg_i(ev_msg_i),
    .ev_v_o(ev_v_o), .ev_chan_o(ev_chan_o), .ev_stamp_o(ev_stamp_o), .ev_msg_o(ev_msg_o),
    .ev_yumi_i(ev_yumi_i), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one queue per channel, a cycle count, and the offer that stays put until taken
  typedef logic [stamp_w+msg_w-1:0] ent_t;
  ent_t         mq [4][$];
  logic [31:0]  m_stamp;
  int           m_last;
  bit           m_held;
  int           m_held_ch;
  int           m_drop [4];
  bit           m_ovf;

  function automatic void m_reset();
    for (int c = 0; c < 4; c++) begin
      mq[c].delete();
      m_drop[c] = 0;
    end
    m_stamp = 0; m_last = 3; m_held = 0; m_held_ch = 0; m_ovf = 0;
  endfunction

  function automatic void m_offer(output bit v, output int ch);
    v = 0; ch = 0;
    if (m_held) begin
      v = 1; ch = m_held_ch;
    end else begin
      for (int i = 1; i <= 4; i++) begin
        int c = (m_last + i) % 4;
        if (!v && mq[c].size() > 0) begin v = 1; ch = c; end
      end
    end
  endfunction

  function automatic void m_update(input bit en, input logic [3:0] v, input logic [31:0] msgs,
                                   input bit offered, input int och, input bit took);
    int   sz [4];
    ent_t tmp;
    for (int c = 0; c < 4; c++) sz[c] = mq[c].size();
    if (offered) begin
      if (took) begin
        tmp = mq[och].pop_front();
        m_last = och; m_held = 0;
      end else begin
        m_held = 1; m_held_ch = och;
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (en && v[c]) begin
        if (sz[c] >= els) begin
          if (m_drop[c] < 255) m_drop[c]++;
          m_ovf = 1;
        end else begin
          mq[c].push_back({m_stamp, msgs[c*msg_w +: msg_w]});
        end
      end
    end
    m_stamp = m_stamp + 1;
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, answer yumi, advance model at posedge
  task automatic step(input bit en, input logic [3:0] v, input logic [31:0] msgs, input bit want_yumi);
    bit   ev;
    int   ech;
    ent_t h;
    en_i = en; ev_v_i = v; ev_msg_i = msgs; ev_yumi_i = 1'b0;
    @(negedge clk_i);
    m_offer(ev, ech);
    check_eq("ev_v", ev_v_o, ev);
    if (ev) begin
      h = mq[ech][0];
      check_eq("ev_chan", ev_chan_o, ech);
      check_eq("ev_stamp", ev_stamp_o, h[stamp_w+msg_w-1 -: stamp_w]);
      check_eq("ev_msg", ev_msg_o, h[msg_w-1:0]);
    end
    for (int c = 0; c < 4; c++) check_eq("drop_cnt", drop_cnt_o[c*drop_w +: drop_w], m_drop[c]);
    check_eq("overflow", overflow_o, m_ovf);
    ev_yumi_i = want_yumi & ev_v_o;
    @(posedge clk_i);
    m_update(en, v, msgs, ev, ech, ev_yumi_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    ev_v_i = '0; ev_yumi_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    m_reset();
  endtask

  initial begin
    m_reset();
    do_reset();
    check_eq("rst_v", ev_v_o, 0);
    check_eq("rst_drop", drop_cnt_o, 0);
    check_eq("rst_ovf", overflow_o, 0);

    // Single ch1 event fired at stamp 10
    while (m_stamp != 10) step(1, 4'h0, '0, 1);
    step(1, 4'b0010, 32'h0000_A500, 1);
    check_eq("t1_v", ev_v_o, 1);
    check_eq("t1_chan", ev_chan_o, 1);
    check_eq("t1_stamp", ev_stamp_o, 10);
    check_eq("t1_msg", ev_msg_o, 8'hA5);
    step(1, 4'h0, '0, 1);
    check_eq("t1_empty", ev_v_o, 0);

    // All four channels at once, twice, from the reset arbitration point
    do_reset();
    step(1, 4'hF, 32'h4433_2211, 1);
    repeat (4) step(1, 4'h0, '0, 1);
    step(1, 4'hF, 32'h8877_6655, 1);
    repeat (5) step(1, 4'h0, '0, 1);

    // ch2 burst of three with consumer stalled
    repeat (3) step(1, 4'b0100, $urandom, 0);
    check_eq("t3_drop2", drop_cnt_o[2*drop_w +: drop_w], 1);
    check_eq("t3_ovf", overflow_o, 1);
    repeat (4) step(1, 4'h0, '0, 1);

    // ch0 offer held for five cycles while ch3 fires
    step(1, 4'b0001, 32'h0000_00C3, 0);
    repeat (5) step(1, 4'b1000, $urandom, 0);
    step(1, 4'h0, '0, 1);
    check_eq("t4_v", ev_v_o, 1);
    check_eq("t4_chan", ev_chan_o, 3);
    repeat (4) step(1, 4'h0, '0, 1);

    // Capture disabled: nothing accepted, nothing dropped
    repeat (10) step(0, 4'hF, $urandom, 1);
    check_eq("t6_v", ev_v_o, 0);
    step(1, 4'b0001, 32'h0000_005A, 1);
    step(1, 4'h0, '0, 1);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] v;
      for (int c = 0; c < 4; c++) v[c] = ($urandom_range(9, 0) < 3);
      step($urandom_range(9, 0) != 0, v, $urandom, $urandom_range(1, 0) == 1);
    end

    // Saturating drop counter on ch0, then reset in the middle of the stream
    repeat (302) step(1, 4'b0001, $urandom, 0);
    check_eq("t5_sat", drop_cnt_o[drop_w-1:0], 255);
    ev_v_i = 4'hF;
    #3 reset_i = 1'b1;
    #1;
    check_eq("t5_rst_v", ev_v_o, 0);
    check_eq("t5_rst_drop", drop_cnt_o, 0);
    check_eq("t5_rst_ovf", overflow_o, 0);
    do_reset();
    step(1, 4'h0, '0, 1);
    step(1, 4'b0110, $urandom, 1);
    repeat (4) step(1, 4'h0, '0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
